// File: rtl/mem_arbiter_nch_pkg.sv
// Shared constants for the N-channel byte-wide memory arbiter: FSM encoding,
// IO address decode and parameter-width helpers.
package mem_arbiter_nch_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Addresses with [17:16] == IO_HI belong to the UART and honour io_buffer_full.
  localparam logic [1:0]  IO_HI  = 2'b11;
  localparam int unsigned IO_LSB = 16;

  function automatic int len_w(input int data_w);
    return $clog2(data_w / 8) + 1;
  endfunction

  function automatic int idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_nch_if.sv
// Requester and memory-pin bundle of the arbiter; slave = arbiter side,
// master = the cache/LSB layer plus the RAM/IO pins.
interface mem_arbiter_nch_if
  import mem_arbiter_nch_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = len_w(DATA_W)
);

  logic                       clear;
  logic [NUM_CH-1:0]          req_valid;
  logic [NUM_CH-1:0]          req_we;
  logic [NUM_CH*ADDR_W-1:0]   req_addr;
  logic [NUM_CH*LEN_W-1:0]    req_len;
  logic [NUM_CH*DATA_W-1:0]   req_wdata;
  logic [NUM_CH-1:0]          resp_done;
  logic [DATA_W-1:0]          resp_data;
  logic [7:0]                 mem_din;
  logic [7:0]                 mem_dout;
  logic [ADDR_W-1:0]          mem_a;
  logic                       mem_wr;
  logic                       io_buffer_full;

  modport slave (
    input  clear, req_valid, req_we, req_addr, req_len, req_wdata,
    input  mem_din, io_buffer_full,
    output resp_done, resp_data, mem_dout, mem_a, mem_wr
  );

  modport master (
    output clear, req_valid, req_we, req_addr, req_len, req_wdata,
    output mem_din, io_buffer_full,
    input  resp_done, resp_data, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_arbiter_nch_rr_arbiter.sv
// Combinational round-robin pick: first requester above ptr_i, wrapping.
module mem_arbiter_nch_rr_arbiter
  import mem_arbiter_nch_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);

  logic             found;
  logic [IDX_W-1:0] cidx;

  always_comb begin
    found = 1'b0;
    cidx  = '0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cidx = IDX_W'((int'(ptr_i) + k) % NUM_CH);
      if (!found && req_i[cidx]) begin
        found       = 1'b1;
        gnt_o[cidx] = 1'b1;
        idx_o       = cidx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mem_arbiter_nch.sv
// N-channel round-robin arbiter onto the byte-wide RAM/IO bus with
// multi-byte transfers, UART back-pressure and flush abort of reads.
//
// state   | meaning
// IDLE    | arbitrate, latch the granted request
// RD      | issue read addresses, capture bytes one cycle later
// WR      | drive one write byte per cycle, stall on full UART
// DONE    | one-cycle resp_done to the granted channel
module mem_arbiter_nch
  import mem_arbiter_nch_pkg::*;
#(
  parameter int                NUM_CH     = 2,
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                LEN_W      = len_w(DATA_W),
  parameter logic [NUM_CH-1:0] FLUSH_MASK = {NUM_CH{1'b1}}
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  mem_arbiter_nch_if.slave  bus
);

  localparam int               NB    = DATA_W / 8;
  localparam int               IDX_W = idx_w(NUM_CH);
  localparam logic [LEN_W-1:0] NB_L  = LEN_W'(NB);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  i_q, i_d, i_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d, a_prev_q;
  logic [7:0]        dout_q, dout_d;

  logic [NUM_CH-1:0] req_eff, arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we, len_ok, stall, flush_rd;

  assign req_eff = bus.req_valid & ~(bus.clear ? FLUSH_MASK : '0);

  mem_arbiter_nch_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .req_i  (req_eff),
    .ptr_i  (rr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  assign sel_addr  = bus.req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
  assign sel_len   = bus.req_len[int'(arb_idx)*LEN_W +: LEN_W];
  assign sel_wdata = bus.req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
  assign sel_we    = bus.req_we[arb_idx];
  assign len_ok    = (sel_len != '0) && (sel_len <= NB_L);
  assign stall     = (mem_a_q[IO_LSB +: 2] == IO_HI) && bus.io_buffer_full;
  assign flush_rd  = bus.clear && !we_q && (|(gnt_q & FLUSH_MASK));
  assign i_nxt     = i_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    i_d     = i_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_a_d = mem_a_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          rr_d    = arb_idx;
          we_d    = sel_we;
          addr_d  = sel_addr;
          len_d   = sel_len;
          wdata_d = sel_wdata;
          i_d     = '0;
          rdata_d = '0;
          if (!len_ok) begin
            state_d = ST_DONE;
          end else begin
            mem_a_d = sel_addr;
            dout_d  = sel_wdata[7:0];
            state_d = sel_we ? ST_WR : ST_RD;
          end
        end
      end
      ST_RD: begin
        if (flush_rd) begin
          state_d = ST_IDLE;
        end else begin
          // byte i-1 arrives now, its address having been driven last cycle
          for (int b = 0; b < NB; b++) begin
            if (LEN_W'(b + 1) == i_q) rdata_d[8*b +: 8] = bus.mem_din;
          end
          if (i_nxt < len_q) mem_a_d = addr_q + ADDR_W'(i_nxt);
          if (i_q == len_q) state_d = ST_DONE;
          else              i_d     = i_nxt;
        end
      end
      ST_WR: begin
        if (!stall) begin
          if (i_nxt == len_q) begin
            state_d = ST_DONE;
          end else begin
            i_d     = i_nxt;
            mem_a_d = addr_q + ADDR_W'(i_nxt);
            for (int b = 0; b < NB; b++) begin
              if (LEN_W'(b) == i_nxt) dout_d = wdata_q[8*b +: 8];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      rr_q     <= IDX_W'(NUM_CH - 1);
      gnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      i_q      <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mem_a_q  <= '0;
      a_prev_q <= '0;
      dout_q   <= '0;
    end else if (rdy_in) begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      i_q      <= i_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mem_a_q  <= mem_a_d;
      a_prev_q <= mem_a_q;
      dout_q   <= dout_d;
    end
  end

  // While frozen, re-present the previous address so the RAM still returns
  // the byte that is due for capture on the first cycle after resume.
  assign bus.mem_a     = rdy_in ? mem_a_q : a_prev_q;
  assign bus.mem_wr    = rdy_in && (state_q == ST_WR) && !stall;
  assign bus.mem_dout  = dout_q;
  assign bus.resp_data = rdata_q;
  assign bus.resp_done = (rdy_in && (state_q == ST_DONE) && !flush_rd) ? gnt_q : '0;

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Directed bench for mem_arbiter_nch: reads, IO-stalled and flushed writes,
// fairness, flush abort, rdy freeze and mid-transfer reset.
module tb_mem_arbiter_nch;
  import mem_arbiter_nch_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [39:0] wlog[$];

  mem_arbiter_nch_if #(.NUM_CH(2), .DATA_W(32), .ADDR_W(32)) bus ();

  mem_arbiter_nch #(.NUM_CH(2), .DATA_W(32), .ADDR_W(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      default: return a[7:0] ^ a[15:8];
    endcase
  endfunction

  always @(posedge clk_in) begin
    bus.mem_din <= ram_rd(bus.mem_a);
    if (bus.mem_wr) wlog.push_back({bus.mem_a, bus.mem_dout});
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic set_req(input int ch, input logic we, input logic [31:0] a,
                         input logic [2:0] len, input logic [31:0] wd);
    bus.req_we[ch]             = we;
    bus.req_addr[ch*32 +: 32]  = a;
    bus.req_len[ch*3 +: 3]     = len;
    bus.req_wdata[ch*32 +: 32] = wd;
    bus.req_valid[ch]          = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wb, nd, cnt0, cnt1, exp_ch, d0;
    logic [31:0] wd;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    bus.clear = 1'b0;
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_len = '0;
    bus.req_wdata = '0;
    bus.io_buffer_full = 1'b0;
    repeat (3) tick();
    #1;
    chk("rst_state", dut.state_q, ST_IDLE);
    chk("rst_rr", dut.rr_q, 1);
    chk("rst_done", bus.resp_done, 0);
    chk("rst_data", bus.resp_data, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_dout", bus.mem_dout, 0);
    tick();
    rst_in = 1'b1;

    // single 4-byte read on ch1
    tick();
    set_req(1, 1'b0, 32'h100, 3'd4, 32'h0);
    #1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      #1;
      if (c <= 4) chk("t1_addr", bus.mem_a, 32'h100 + c - 1);
      if (c == 5) chk("t1_early_done", bus.resp_done, 0);
      if (c == 6) begin
        chk("t1_done", bus.resp_done, 2'b10);
        chk("t1_data", bus.resp_data, 32'h44332211);
      end
    end
    tick();
    bus.req_valid = '0;

    // IO write held off by a full UART for three cycles
    tick();
    wb = wlog.size();
    set_req(1, 1'b1, 32'h30000, 3'd1, 32'h41);
    bus.io_buffer_full = 1'b1;
    #1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) bus.io_buffer_full = 1'b0;
      #1;
      if (c <= 3) chk("t2_stall_wr", bus.mem_wr, 0);
      if (c == 4) begin
        chk("t2_wr", bus.mem_wr, 1);
        chk("t2_addr", bus.mem_a, 32'h30000);
        chk("t2_dout", bus.mem_dout, 8'h41);
        chk("t2_early_done", bus.resp_done, 0);
      end
      if (c == 5) chk("t2_done", bus.resp_done, 2'b10);
    end
    tick();
    bus.req_valid = '0;
    chk("t2_nwrites", wlog.size() - wb, 1);
    if (wlog.size() > wb) chk("t2_log", wlog[wb], {32'h30000, 8'h41});

    // fairness: both channels always requesting single-byte reads
    tick();
    set_req(0, 1'b0, 32'h200, 3'd1, 32'h0);
    set_req(1, 1'b0, 32'h300, 3'd1, 32'h0);
    nd = 0; cnt0 = 0; cnt1 = 0; exp_ch = 0;
    for (int c = 0; c < 120 && nd < 20; c++) begin
      tick();
      #1;
      if (bus.resp_done != 2'b00) begin
        chk("t3_order", bus.resp_done, (exp_ch == 0) ? 2'b01 : 2'b10);
        chk("t3_data", bus.resp_data, (exp_ch == 0) ? 32'h02 : 32'h03);
        if (bus.resp_done[0]) cnt0++;
        if (bus.resp_done[1]) cnt1++;
        exp_ch = 1 - exp_ch;
        nd++;
      end
    end
    chk("t3_count", nd, 20);
    chk("t3_cnt0", cnt0, 10);
    chk("t3_cnt1", cnt1, 10);
    tick();
    bus.req_valid = '0;

    // flush aborts ch0 read at byte 2, pending ch1 write proceeds
    tick();
    set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
    set_req(1, 1'b1, 32'h400, 3'd2, 32'h0000BEEF);
    d0 = 0;
    #1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 3) bus.clear = 1'b1;
      if (c == 4) begin
        bus.clear = 1'b0;
        bus.req_valid[0] = 1'b0;
      end
      #1;
      if (bus.resp_done[0]) d0++;
      if (c == 3) chk("t4_addr_b2", bus.mem_a, 32'h102);
      if (c == 4) chk("t4_abort_idle", dut.state_q, ST_IDLE);
      if (c == 5) begin
        chk("t4_wr0", bus.mem_wr, 1);
        chk("t4_a0", bus.mem_a, 32'h400);
        chk("t4_d0", bus.mem_dout, 8'hEF);
      end
      if (c == 6) begin
        chk("t4_a1", bus.mem_a, 32'h401);
        chk("t4_d1", bus.mem_dout, 8'hBE);
      end
      if (c == 7) chk("t4_done", bus.resp_done, 2'b10);
    end
    chk("t4_no_done0", d0, 0);
    tick();
    bus.req_valid = '0;

    // flush during a ch1 write never aborts it
    tick();
    wd = 32'hDDCCBBAA;
    wb = wlog.size();
    set_req(1, 1'b1, 32'h500, 3'd4, wd);
    #1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.clear = (c == 2 || c == 5);
      #1;
      if (c <= 4) begin
        chk("t5_wr", bus.mem_wr, 1);
        chk("t5_addr", bus.mem_a, 32'h500 + c - 1);
        chk("t5_dout", bus.mem_dout, wd[8*(c-1) +: 8]);
      end
      if (c == 5) chk("t5_done", bus.resp_done, 2'b10);
    end
    tick();
    bus.clear = 1'b0;
    bus.req_valid = '0;
    chk("t5_nwrites", wlog.size() - wb, 4);

    // flush coincident with DONE of a masked read swallows the pulse
    tick();
    set_req(0, 1'b0, 32'h210, 3'd1, 32'h0);
    #1;
    tick();
    tick();
    tick();
    bus.clear = 1'b1;
    #1;
    chk("t5b_supp", bus.resp_done, 0);
    tick();
    bus.clear = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("t5b_idle", dut.state_q, ST_IDLE);

    // zero-length request completes immediately with no bus activity
    tick();
    set_req(1, 1'b0, 32'h220, 3'd0, 32'h0);
    #1;
    tick();
    #1;
    chk("t5c_done", bus.resp_done, 2'b10);
    chk("t5c_data", bus.resp_data, 0);
    chk("t5c_wr", bus.mem_wr, 0);
    tick();
    bus.req_valid = '0;

    // rdy low for five cycles mid-read
    tick();
    set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
    #1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 3) rdy_in = 1'b0;
      if (c == 8) rdy_in = 1'b1;
      #1;
      if (c >= 3 && c <= 7) chk("t6_frz_done", bus.resp_done, 0);
      if (c == 10) chk("t6_early_done", bus.resp_done, 0);
      if (c == 11) begin
        chk("t6_done", bus.resp_done, 2'b01);
        chk("t6_data", bus.resp_data, 32'h44332211);
      end
    end

    // reset lands in the middle of a ch1 write
    tick();
    bus.req_valid[0] = 1'b0;
    wb = wlog.size();
    set_req(1, 1'b1, 32'h600, 3'd4, 32'h12345678);
    #1;
    tick();
    #1;
    chk("t6_wr0", bus.mem_wr, 1);
    chk("t6_wa0", bus.mem_a, 32'h600);
    tick();
    rst_in = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("t6_rst_state", dut.state_q, ST_IDLE);
    chk("t6_rst_wr", bus.mem_wr, 0);
    chk("t6_rst_a", bus.mem_a, 0);
    chk("t6_rst_dout", bus.mem_dout, 0);
    chk("t6_rst_data", bus.resp_data, 0);
    chk("t6_rst_done", bus.resp_done, 0);
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    #1;
    chk("t6_post_idle", dut.state_q, ST_IDLE);
    chk("t6_nwrites", wlog.size() - wb, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
